// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/sequencing controller:
// forwarding-select codes and the data-memory FSM state type.
package pipe_ctrl_pkg;

  // ID-stage operand mux selects
  localparam logic [1:0] FWD_RF      = 2'b00;  // register file
  localparam logic [1:0] FWD_EXE     = 2'b01;  // EXE-stage ALU result
  localparam logic [1:0] FWD_MEM_ALU = 2'b10;  // MEM-stage ALU result
  localparam logic [1:0] FWD_MEM_LD  = 2'b11;  // MEM-stage load data

  // Data-memory access sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } mem_state_t;

endpackage

// File: rtl/fwd_unit.sv
// Forwarding-select logic for one ID-stage source operand.
// Youngest producer wins: an EXE ALU result beats anything in MEM.
// An EXE load cannot be forwarded yet (load-use stall covers that case).
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic       use_src,
  input  logic [4:0] exe_rn,
  input  logic       exe_wreg,
  input  logic       exe_m2reg,
  input  logic [4:0] mem_rn,
  input  logic       mem_wreg,
  input  logic       mem_m2reg,
  output logic [1:0] fwd
);

  // Priority select: EXE ALU, then MEM (ALU or load data), else regfile
  always_comb begin
    fwd = FWD_RF;
    if (use_src && (src != 5'd0)) begin
      if (exe_wreg && !exe_m2reg && (exe_rn == src)) begin
        fwd = FWD_EXE;
      end else if (mem_wreg && (mem_rn == src)) begin
        fwd = mem_m2reg ? FWD_MEM_LD : FWD_MEM_ALU;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline.
// - operand forwarding selects (one fwd_unit per operand)
// - load-use detection, one bubble per hazard
// - request/acknowledge sequencer toward a variable-latency data memory,
//   freezing the pipeline registers while an access is outstanding
// Optional macro PIPE_HAZARD_CTRL_STATS_EN adds saturating stall counters.
//
// Memory handshake: dmem_req is high in the IDLE cycle that sees a MEM-stage
// load/store and in every WAIT cycle. The memory answers with a one-cycle
// dmem_ack, sampled only in WAIT (latency >= 1 cycle); the ack is ignored in
// IDLE and DONE. Read data stays valid until the next request, so MEM/WB
// captures it in the DONE cycle when the pipeline advances.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       exe_rn,
  input  logic             exe_wreg,
  input  logic             exe_m2reg,
  input  logic [4:0]       mem_rn,
  input  logic             mem_wreg,
  input  logic             mem_m2reg,
  input  logic             mem_wmem,
  input  logic             dmem_ack,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idexe_we,
  output logic             idexe_bubble,
  output logic             exemem_we,
  output logic             memwb_bubble,
  output logic             dmem_req,
  output logic             timeout_err,
`ifdef PIPE_HAZARD_CTRL_STATS_EN
  output logic [CNT_W-1:0] stall_lu_cnt,
  output logic [CNT_W-1:0] stall_mem_cnt,
`endif
  output mem_state_t       dbg_state
);

  localparam int CW = $clog2(TIMEOUT);

  mem_state_t    state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_inc;
  logic          mem_access, freeze, lu, to_hit, timeout_set;

  fwd_unit u_fwd_a (
    .src(id_rs), .use_src(id_use_rs),
    .exe_rn(exe_rn), .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg),
    .mem_rn(mem_rn), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
    .fwd(fwda)
  );

  fwd_unit u_fwd_b (
    .src(id_rt), .use_src(id_use_rt),
    .exe_rn(exe_rn), .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg),
    .mem_rn(mem_rn), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
    .fwd(fwdb)
  );

  assign mem_access = mem_m2reg | mem_wmem;
  // WAIT lasts TIMEOUT-1 cycles: the counter starts at 0 on entry
  assign wait_inc   = wait_cnt + 1'b1;
  assign to_hit     = (wait_inc == CW'(TIMEOUT - 1));
  assign lu = exe_wreg && exe_m2reg && (exe_rn != 5'd0) &&
              ((id_use_rs && (id_rs == exe_rn)) ||
               (id_use_rt && (id_rt == exe_rn)));

  // Sequencer next state; freeze and timeout detection decoded here
  always_comb begin
    state_nxt   = state;
    freeze      = 1'b0;
    timeout_set = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_access) begin
          freeze    = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        freeze = 1'b1;
        if (dmem_ack) begin
          state_nxt = ST_DONE;
        end else if (to_hit) begin
          state_nxt   = ST_DONE;
          timeout_set = 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign dmem_req  = freeze;
  assign dbg_state = state;

  // Sequencer state, wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state == ST_WAIT) ? wait_inc : '0;
      if (timeout_set) timeout_err <= 1'b1;
    end
  end

  // Pipeline register controls: freeze beats load-use, load-use beats run
  always_comb begin
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    idexe_we     = 1'b1;
    idexe_bubble = 1'b0;
    exemem_we    = 1'b1;
    memwb_bubble = 1'b0;
    if (freeze) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      idexe_we     = 1'b0;
      exemem_we    = 1'b0;
      memwb_bubble = 1'b1;
    end else if (lu) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      idexe_bubble = 1'b1;
    end
  end

`ifdef PIPE_HAZARD_CTRL_STATS_EN
  logic lu_bubble;
  assign lu_bubble = lu & ~freeze;

  // Saturating stall statistics
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stall_lu_cnt  <= '0;
      stall_mem_cnt <= '0;
    end else begin
      if (lu_bubble && (stall_lu_cnt != {CNT_W{1'b1}}))
        stall_lu_cnt <= stall_lu_cnt + 1'b1;
      if (freeze && (stall_mem_cnt != {CNT_W{1'b1}}))
        stall_mem_cnt <= stall_mem_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (instance built with TIMEOUT=4).
// Combinational vectors come from a table; multi-cycle sequences push
// expected {state, timeout_err, controls} words into exp_q, one per cycle.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int W     = 10;
  localparam int CNT_W = 32;
  // control word order: {pc_we, ifid_we, idexe_we, idexe_bubble, exemem_we, memwb_bubble, dmem_req}
  localparam logic [6:0] RUN = 7'b1110100;
  localparam logic [6:0] LU  = 7'b0011100;
  localparam logic [6:0] FRZ = 7'b0000011;

  logic clk, clrn;
  logic [4:0] id_rs, id_rt, exe_rn, mem_rn;
  logic id_use_rs, id_use_rt, exe_wreg, exe_m2reg, mem_wreg, mem_m2reg, mem_wmem, dmem_ack;
  logic [1:0] fwda, fwdb;
  logic pc_we, ifid_we, idexe_we, idexe_bubble, exemem_we, memwb_bubble, dmem_req, timeout_err;
  mem_state_t dbg_state;
`ifdef PIPE_HAZARD_CTRL_STATS_EN
  logic [CNT_W-1:0] stall_lu_cnt, stall_mem_cnt;
`endif
  logic [6:0] ctl;
  assign ctl = {pc_we, ifid_we, idexe_we, idexe_bubble, exemem_we, memwb_bubble, dmem_req};

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .clrn(clrn),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .exe_rn(exe_rn), .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg),
    .mem_rn(mem_rn), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_wmem(mem_wmem),
    .dmem_ack(dmem_ack),
    .fwda(fwda), .fwdb(fwdb),
    .pc_we(pc_we), .ifid_we(ifid_we), .idexe_we(idexe_we), .idexe_bubble(idexe_bubble),
    .exemem_we(exemem_we), .memwb_bubble(memwb_bubble),
    .dmem_req(dmem_req), .timeout_err(timeout_err),
`ifdef PIPE_HAZARD_CTRL_STATS_EN
    .stall_lu_cnt(stall_lu_cnt), .stall_mem_cnt(stall_mem_cnt),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs, rt;
    logic       urs, urt;
    logic [4:0] exe_rn;
    logic       ew, em;
    logic [4:0] mem_rn;
    logic       mw, mm, mwm;
    logic [1:0] fa, fb;
    logic [6:0] ctl;
  } vec_t;

  vec_t tv[15];

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                              input logic urs, input logic urt,
                              input logic [4:0] ern, input logic ew, input logic em,
                              input logic [4:0] mrn, input logic mw, input logic mm,
                              input logic mwm, input logic [1:0] fa, input logic [1:0] fb,
                              input logic [6:0] c);
    vec_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
    v.exe_rn = ern; v.ew = ew; v.em = em;
    v.mem_rn = mrn; v.mw = mw; v.mm = mm; v.mwm = mwm;
    v.fa = fa; v.fb = fb; v.ctl = c;
    return v;
  endfunction

  // driver tasks
  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt,
                        input logic [4:0] ern, input logic ew, input logic em,
                        input logic [4:0] mrn, input logic mw, input logic mm,
                        input logic mwm);
    id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    exe_rn = ern; exe_wreg = ew; exe_m2reg = em;
    mem_rn = mrn; mem_wreg = mw; mem_m2reg = mm; mem_wmem = mwm;
  endtask

  task automatic set_idle();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    dmem_ack = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input mem_state_t s, input logic e, input logic [6:0] c);
    exp_q.push_back({s, e, c});
  endtask

  // scoreboard step: compare at negedge, return at posedge+1 for next drive
  task automatic step_chk(input string nm);
    logic [W-1:0] e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: expected queue empty", nm);
    end else begin
      e = exp_q.pop_front();
      chk(nm, {22'd0, dbg_state, timeout_err, ctl}, {22'd0, e});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int req_cycles;
    // ---------------- reset ----------------
    clrn = 1'b0;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    chk("reset_err", {31'd0, timeout_err}, 32'd0);
    chk("reset_ctl", {25'd0, ctl}, {25'd0, RUN});
`ifdef PIPE_HAZARD_CTRL_STATS_EN
    chk("reset_lu_cnt", stall_lu_cnt, 32'd0);
    chk("reset_mem_cnt", stall_mem_cnt, 32'd0);
`endif
    @(negedge clk);
    clrn = 1'b1;
    @(posedge clk);
    #1;

    // ---------------- combinational table ----------------
    //          rs  rt  urs urt ern ew em mrn mw mm mwm  fa     fb     ctl
    tv[0]  = mk(3,  0,  1,  1,  3,  1, 0, 0,  0, 0, 0, 2'b01, 2'b00, RUN);
    tv[1]  = mk(1,  0,  1,  1,  0,  1, 0, 0,  0, 0, 0, 2'b00, 2'b00, RUN);
    tv[2]  = mk(3,  0,  0,  1,  3,  1, 0, 0,  0, 0, 0, 2'b00, 2'b00, RUN);
    tv[3]  = mk(3,  0,  1,  1,  3,  0, 0, 0,  0, 0, 0, 2'b00, 2'b00, RUN);
    tv[4]  = mk(0,  7,  1,  1,  0,  0, 0, 7,  1, 0, 0, 2'b00, 2'b10, RUN);
    tv[5]  = mk(7,  0,  1,  1,  0,  0, 0, 7,  1, 1, 0, 2'b11, 2'b00, FRZ);
    tv[6]  = mk(9,  9,  1,  1,  9,  1, 0, 9,  1, 0, 0, 2'b01, 2'b01, RUN);
    tv[7]  = mk(4,  0,  1,  1,  4,  1, 1, 4,  1, 0, 0, 2'b10, 2'b00, LU);
    tv[8]  = mk(0,  5,  1,  1,  5,  1, 1, 0,  0, 0, 0, 2'b00, 2'b00, LU);
    tv[9]  = mk(0,  0,  1,  1,  0,  1, 1, 0,  0, 0, 0, 2'b00, 2'b00, RUN);
    tv[10] = mk(0,  5,  0,  0,  5,  1, 1, 0,  0, 0, 0, 2'b00, 2'b00, RUN);
    tv[11] = mk(5,  0,  1,  1,  5,  1, 1, 2,  0, 0, 1, 2'b00, 2'b00, FRZ);
    tv[12] = mk(6,  6,  1,  0,  0,  0, 0, 6,  0, 0, 0, 2'b00, 2'b00, RUN);
    tv[13] = mk(0,  8,  1,  1,  0,  0, 0, 8,  1, 1, 0, 2'b00, 2'b11, FRZ);
    tv[14] = mk(0,  0,  1,  1,  0,  1, 0, 0,  1, 0, 0, 2'b00, 2'b00, RUN);
    for (int i = 0; i < 15; i++) begin
      set_in(tv[i].rs, tv[i].rt, tv[i].urs, tv[i].urt, tv[i].exe_rn, tv[i].ew, tv[i].em,
             tv[i].mem_rn, tv[i].mw, tv[i].mm, tv[i].mwm);
      @(negedge clk);
      chk($sformatf("vec%0d", i), {26'd0, fwda, fwdb, ctl[6:5]},
          {26'd0, tv[i].fa, tv[i].fb, tv[i].ctl[6:5]});
      chk($sformatf("vec%0d_ctl", i), {25'd0, ctl}, {25'd0, tv[i].ctl});
      set_idle();  // keep the sequencer in IDLE between vectors
      @(posedge clk);
      #1;
    end

    // ---------------- load-use, then load forwarded from MEM ----------------
    push_exp(ST_IDLE, 1'b0, LU);
    push_exp(ST_IDLE, 1'b0, FRZ);
    push_exp(ST_WAIT, 1'b0, FRZ);
    push_exp(ST_DONE, 1'b0, RUN);
    push_exp(ST_IDLE, 1'b0, RUN);
    set_in(0, 5, 0, 1, 5, 1, 1, 0, 0, 0, 0);
    #1 chk("lu_fwdb", {30'd0, fwdb}, 32'd0);
    step_chk("lu_a0");
    set_in(0, 5, 0, 1, 0, 0, 0, 5, 1, 1, 0);
    #1 chk("lu_fwdb_mem", {30'd0, fwdb}, {30'd0, FWD_MEM_LD});
    step_chk("lu_a1");
    dmem_ack = 1'b1;
    step_chk("lu_a2");
    dmem_ack = 1'b0;
    #1 chk("lu_fwdb_done", {30'd0, fwdb}, {30'd0, FWD_MEM_LD});
    step_chk("lu_a3");
    set_idle();
    step_chk("lu_a4");

    // ---------------- store, ack three cycles after request ----------------
    push_exp(ST_IDLE, 1'b0, FRZ);
    push_exp(ST_WAIT, 1'b0, FRZ);
    push_exp(ST_WAIT, 1'b0, FRZ);
    push_exp(ST_WAIT, 1'b0, FRZ);
    push_exp(ST_DONE, 1'b0, RUN);
    push_exp(ST_IDLE, 1'b0, RUN);
    req_cycles = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int c = 0; c < 6; c++) begin
      dmem_ack = (c == 3);
      if (c == 5) set_idle();
      #1 if (dmem_req) req_cycles++;
      step_chk($sformatf("st_b%0d", c));
    end
    chk("st_req_cycles", req_cycles, 32'd4);

    // ---------------- timeout: ack never comes ----------------
    push_exp(ST_IDLE, 1'b0, FRZ);
    push_exp(ST_WAIT, 1'b0, FRZ);
    push_exp(ST_WAIT, 1'b0, FRZ);
    push_exp(ST_WAIT, 1'b0, FRZ);
    push_exp(ST_DONE, 1'b1, RUN);
    push_exp(ST_IDLE, 1'b1, RUN);
    push_exp(ST_IDLE, 1'b1, RUN);
    set_in(0, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0);
    for (int c = 0; c < 7; c++) begin
      if (c == 5) set_idle();
      step_chk($sformatf("to_c%0d", c));
    end

    // ---------------- back-to-back loads, lu held off by freeze ----------------
    push_exp(ST_IDLE, 1'b1, FRZ);
    push_exp(ST_WAIT, 1'b1, FRZ);
    push_exp(ST_DONE, 1'b1, RUN);
    push_exp(ST_IDLE, 1'b1, FRZ);
    push_exp(ST_WAIT, 1'b1, FRZ);
    push_exp(ST_DONE, 1'b1, LU);
    push_exp(ST_IDLE, 1'b1, RUN);
    set_in(0, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0);
    step_chk("b2b_d0");
    dmem_ack = 1'b1;
    step_chk("b2b_d1");
    dmem_ack = 1'b0;
    step_chk("b2b_d2");
    set_in(8, 0, 1, 0, 8, 1, 1, 3, 1, 1, 0);
    step_chk("b2b_d3");
    dmem_ack = 1'b1;
    step_chk("b2b_d4");
    dmem_ack = 1'b0;
    step_chk("b2b_d5");
    set_idle();
    step_chk("b2b_d6");
`ifdef PIPE_HAZARD_CTRL_STATS_EN
    chk("stat_lu_cnt", stall_lu_cnt, 32'd2);
    chk("stat_mem_cnt", stall_mem_cnt, 32'd14);
`endif

    // ---------------- reset in the middle of WAIT ----------------
    push_exp(ST_IDLE, 1'b1, FRZ);
    push_exp(ST_WAIT, 1'b1, FRZ);
    set_in(0, 0, 0, 0, 0, 0, 0, 4, 1, 1, 0);
    step_chk("rst_e0");
    step_chk("rst_e1");
    #2;
    clrn = 1'b0;
    set_idle();
    #1;
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    chk("rst_err", {31'd0, timeout_err}, 32'd0);
`ifdef PIPE_HAZARD_CTRL_STATS_EN
    chk("rst_lu_cnt", stall_lu_cnt, 32'd0);
    chk("rst_mem_cnt", stall_mem_cnt, 32'd0);
`endif
    @(negedge clk);
    clrn = 1'b1;
    @(posedge clk);
    #1;
    push_exp(ST_IDLE, 1'b0, RUN);
    step_chk("rst_after");

    chk("exp_q_drained", exp_q.size(), 32'd0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
